// File: rtl/gat_feat_streamer.sv
// Streams the GAT new-feature BRAM out over AXI-Stream once gat_ready rises.
// Optional macro GAT_FEAT_STREAM_STALL_CNT_EN adds a saturating stall_cnt output.
module gat_feat_streamer #(
    parameter int DATA_WIDTH        = 8,
    parameter int NUM_SUBGRAPHS     = 2708,
    parameter int NUM_FEATURE_OUT   = 16,
    parameter int NEW_FEATURE_DEPTH = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int ADDR_W            = $clog2(NEW_FEATURE_DEPTH) + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gat_ready,
    output logic [ADDR_W-1:0] feat_bram_addrb,
    input  logic [31:0]       feat_bram_dout,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done
`ifdef GAT_FEAT_STREAM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEW_FEATURE_DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e            state_q, state_d;
    logic              gat_ready_q, armed_q, armed_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              issued_all_q, issued_all_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              done_q, done_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       data0_q, data0_d, data1_q, data1_d;
    logic              last0_q, last0_d, last1_q, last1_d;

    logic        pop_s, push_s, rise_s, issue_s, at_last_s;
    logic [1:0]  occ_s;
    logic [31:0] sext_s;
    logic        unused_dout_s;

    assign m_axis_tvalid   = (cnt_q != 2'd0);
    assign m_axis_tdata    = data0_q;
    assign m_axis_tlast    = m_axis_tvalid & last0_q;
    assign feat_bram_addrb = {rd_idx_q, 2'b00};
    assign busy            = (state_q == RUN);
    assign done            = done_q;

    // armed_q only sets after gat_ready is seen low, so a level held through reset never starts a run
    assign armed_d   = armed_q | ~gat_ready;
    assign rise_s    = gat_ready & ~gat_ready_q & armed_q;
    assign pop_s     = m_axis_tvalid & m_axis_tready;
    assign push_s    = inflight_q;
    assign occ_s     = cnt_q + {1'b0, inflight_q} - {1'b0, pop_s};
    assign at_last_s = (rd_idx_q == LAST_IDX);
    assign issue_s   = (state_q == RUN) & ~issued_all_q & (occ_s < 2'd2);
    assign sext_s    = {{(32-DATA_WIDTH){feat_bram_dout[DATA_WIDTH-1]}}, feat_bram_dout[DATA_WIDTH-1:0]};
    assign unused_dout_s = ^feat_bram_dout[31:DATA_WIDTH];

    // FSM next state, read issue and index advance (index parks on the last element)
    always_comb begin
        state_d         = state_q;
        rd_idx_d        = rd_idx_q;
        issued_all_d    = issued_all_q;
        done_d          = 1'b0;
        inflight_d      = issue_s;
        inflight_last_d = issue_s & at_last_s;
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    state_d      = RUN;
                    rd_idx_d     = '0;
                    issued_all_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (issue_s) begin
                    if (at_last_s) begin
                        issued_all_d = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end else begin
                    rd_idx_d = rd_idx_q;
                end
                if (pop_s && last0_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry shift FIFO: entry 0 is always the head, so tdata is a plain register
    always_comb begin
        cnt_d   = occ_s;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    data0_d = sext_s;
                    last0_d = inflight_last_q;
                end else begin
                    data1_d = sext_s;
                    last1_d = inflight_last_q;
                end
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    data0_d = sext_s;
                    last0_d = inflight_last_q;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = sext_s;
                    last1_d = inflight_last_q;
                end
            end
            default: begin
                cnt_d = occ_s;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            gat_ready_q     <= 1'b0;
            armed_q         <= 1'b0;
            rd_idx_q        <= '0;
            issued_all_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            cnt_q           <= 2'd0;
            data0_q         <= 32'd0;
            data1_q         <= 32'd0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            gat_ready_q     <= gat_ready;
            armed_q         <= armed_d;
            rd_idx_q        <= rd_idx_d;
            issued_all_q    <= issued_all_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
            cnt_q           <= cnt_d;
            data0_q         <= data0_d;
            data1_q         <= data1_d;
            last0_q         <= last0_d;
            last1_q         <= last1_d;
        end
    end

`ifdef GAT_FEAT_STREAM_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of back-pressured cycles, cleared when a run starts
    always_comb begin
        if ((state_q == IDLE) && rise_s) begin
            stall_d = 32'd0;
        end else if ((state_q == RUN) && m_axis_tvalid && !m_axis_tready
                     && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_gat_feat_streamer.sv
// Directed bench for gat_feat_streamer with DEPTH=8 and BRAM element i = i-4.
module tb_gat_feat_streamer;

    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              gat_ready;
    logic [ADDR_W-1:0] feat_bram_addrb;
    logic [31:0]       feat_bram_dout;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              busy;
    logic              done;
`ifdef GAT_FEAT_STREAM_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int vectors;
    int miscompares;

    logic [31:0] beat_q[$];
    logic        last_q[$];
    logic [ADDR_W-1:0] addr_log[$];
    int          cyc;
    int          start_cyc;
    int          first_valid_cyc;
    int          last_beat_cyc;
    int          done_cyc;
    int          done_cnt;
    int          stall_seen;
    int          stable_err;
    logic        hold_pending;
    logic [31:0] hold_data;
    logic        hold_last;

    gat_feat_streamer #(
        .DATA_WIDTH      (8),
        .NUM_SUBGRAPHS   (2),
        .NUM_FEATURE_OUT (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gat_ready       (gat_ready),
        .feat_bram_addrb (feat_bram_addrb),
        .feat_bram_dout  (feat_bram_dout),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .busy            (busy),
        .done            (done)
`ifdef GAT_FEAT_STREAM_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency, junk in the upper bits to exercise sign extension
    always @(posedge clk) begin
        feat_bram_dout <= {24'hA5A5A5, 8'(feat_bram_addrb[4:2]) - 8'd4};
    end

    task automatic clear_logs();
        beat_q.delete();
        last_q.delete();
        addr_log.delete();
        first_valid_cyc = -1;
        last_beat_cyc   = -1;
        done_cyc        = -1;
        done_cnt        = 0;
        stall_seen      = 0;
        stable_err      = 0;
        hold_pending    = 1'b0;
    endtask

    // One clock: entered and left at posedge+1, records beats/addresses/done for this cycle
    task automatic tick(input logic rdy);
        m_axis_tready = rdy;
        if (busy && (addr_log.size() == 0 || addr_log[$] != feat_bram_addrb))
            addr_log.push_back(feat_bram_addrb);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (m_axis_tvalid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hold_pending && (m_axis_tdata != hold_data || m_axis_tlast != hold_last))
                stable_err++;
            if (rdy) begin
                beat_q.push_back(m_axis_tdata);
                last_q.push_back(m_axis_tlast);
                if (m_axis_tlast) last_beat_cyc = cyc;
                hold_pending = 1'b0;
            end else begin
                hold_pending = 1'b1;
                hold_data    = m_axis_tdata;
                hold_last    = m_axis_tlast;
                if (busy) stall_seen++;
            end
        end else if (hold_pending) begin
            stable_err++;
            hold_pending = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_run(input logic rdy);
        clear_logs();
        gat_ready = 1'b1;
        start_cyc = cyc;
        tick(rdy);
        gat_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        gat_ready = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid got=%b want=0", m_axis_tvalid); end
        vectors++; if (m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL rst_tlast got=%b want=0", m_axis_tlast); end
        vectors++; if (m_axis_tdata !== 32'd0) begin miscompares++; $display("FAIL rst_tdata got=%h want=0", m_axis_tdata); end
        vectors++; if (feat_bram_addrb !== 5'd0) begin miscompares++; $display("FAIL rst_addr got=%0d want=0", feat_bram_addrb); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rst_busy_done got=%b%b want=00", busy, done); end
        rst_n = 1'b1;
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        start_run(1'b1);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL lat_busy got=%b want=1", busy); end
        vectors++; if (feat_bram_addrb !== 5'd0) begin miscompares++; $display("FAIL lat_addr got=%0d want=0", feat_bram_addrb); end
        for (int k = 0; k < 60 && done_cnt == 0; k++) tick(1'b1);
        vectors++; if (first_valid_cyc != start_cyc + 3) begin miscompares++; $display("FAIL lat_tvalid got=%0d want=%0d", first_valid_cyc - start_cyc, 3); end
        vectors++; if (beat_q.size() != 8) begin miscompares++; $display("FAIL basic_count got=%0d want=8", beat_q.size()); end
        for (int i = 0; i < 8; i++) begin
            exp = 32'(i - 4);
            vectors++;
            if (i >= beat_q.size() || beat_q[i] !== exp || last_q[i] !== (i == 7)) begin
                miscompares++;
                $display("FAIL basic_beat%0d got=%h/%b want=%h/%b", i, (i < beat_q.size()) ? beat_q[i] : 32'hx, (i < last_q.size()) ? last_q[i] : 1'bx, exp, (i == 7));
            end
        end
        vectors++; if (last_beat_cyc != start_cyc + 10) begin miscompares++; $display("FAIL basic_rate got=%0d want=%0d", last_beat_cyc - start_cyc, 10); end
        vectors++; if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) begin miscompares++; $display("FAIL basic_done got=%0d@%0d want=1@%0d", done_cnt, done_cyc, last_beat_cyc + 1); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle got=%b want=0", busy); end
        vectors++; if (addr_log.size() != 8) begin miscompares++; $display("FAIL addr_count got=%0d want=8", addr_log.size()); end
        for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
            vectors++;
            if (addr_log[i] !== 5'(4 * i)) begin miscompares++; $display("FAIL addr_seq%0d got=%0d want=%0d", i, addr_log[i], 4 * i); end
        end
        tick(1'b1);
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        start_run(1'b1);
        for (int k = 1; k < 100 && done_cnt == 0; k++) tick((k % 4 == 0) || (k % 4 == 3));
        vectors++; if (beat_q.size() != 8 || done_cnt != 1) begin miscompares++; $display("FAIL stall_count got=%0d/%0d want=8/1", beat_q.size(), done_cnt); end
        for (int i = 0; i < 8; i++) begin
            exp = 32'(i - 4);
            vectors++;
            if (i >= beat_q.size() || beat_q[i] !== exp || last_q[i] !== (i == 7)) begin
                miscompares++;
                $display("FAIL stall_beat%0d got=%h want=%h", i, (i < beat_q.size()) ? beat_q[i] : 32'hx, exp);
            end
        end
        vectors++; if (stable_err != 0) begin miscompares++; $display("FAIL stall_hold got=%0d want=0", stable_err); end
`ifdef GAT_FEAT_STREAM_STALL_CNT_EN
        vectors++; if (stall_cnt !== 32'(stall_seen)) begin miscompares++; $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, stall_seen); end
`endif
        tick(1'b1);
    endtask

    task automatic test_second_pulse();
        start_run(1'b1);
        tick(1'b1);
        tick(1'b1);
        gat_ready = 1'b1;
        tick(1'b1);
        gat_ready = 1'b0;
        for (int k = 0; k < 60 && done_cnt == 0; k++) tick(1'b1);
        repeat (6) tick(1'b1);
        vectors++; if (beat_q.size() != 8) begin miscompares++; $display("FAIL pulse_count got=%0d want=8", beat_q.size()); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL pulse_done got=%0d want=1", done_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pulse_idle got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        start_run(1'b1);
        for (int k = 0; k < 30 && beat_q.size() < 3; k++) tick(1'b1);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0
            || feat_bram_addrb !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outs got=%b%b%h/%0d/%b%b want=00 00000000/0/00", m_axis_tvalid, m_axis_tlast, m_axis_tdata, feat_bram_addrb, busy, done);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        tick(1'b1);
        start_run(1'b1);
        for (int k = 0; k < 60 && done_cnt == 0; k++) tick(1'b1);
        vectors++; if (beat_q.size() != 8) begin miscompares++; $display("FAIL midrst_count got=%0d want=8", beat_q.size()); end
        vectors++; if (beat_q.size() == 0 || beat_q[0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL midrst_first got=%h want=fffffffc", (beat_q.size() > 0) ? beat_q[0] : 32'hx); end
        vectors++; if (beat_q.size() < 8 || beat_q[7] !== 32'h0000_0003) begin miscompares++; $display("FAIL midrst_last got=%h want=00000003", (beat_q.size() > 7) ? beat_q[7] : 32'hx); end
        tick(1'b1);
    endtask

    task automatic test_held_high();
        clear_logs();
        gat_ready = 1'b1;
        rst_n     = 1'b0;
        tick(1'b1);
        tick(1'b1);
        rst_n = 1'b1;
        repeat (8) tick(1'b1);
        vectors++; if (first_valid_cyc != -1 || beat_q.size() != 0) begin miscompares++; $display("FAIL held_nostream got=%0d beats want=0", beat_q.size()); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL held_busy got=%b want=0", busy); end
        gat_ready = 1'b0;
        tick(1'b1);
        start_run(1'b1);
        for (int k = 0; k < 60 && done_cnt == 0; k++) tick(1'b1);
        vectors++; if (beat_q.size() != 8 || done_cnt != 1) begin miscompares++; $display("FAIL held_stream got=%0d/%0d want=8/1", beat_q.size(), done_cnt); end
        vectors++; if (first_valid_cyc != start_cyc + 3) begin miscompares++; $display("FAIL held_lat got=%0d want=3", first_valid_cyc - start_cyc); end
        tick(1'b1);
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        start_run(1'b0);
        repeat (20) tick(1'b0);
        vectors++; if (feat_bram_addrb !== 5'd8) begin miscompares++; $display("FAIL bp_addr got=%0d want=8", feat_bram_addrb); end
        vectors++; if (addr_log.size() != 3) begin miscompares++; $display("FAIL bp_reads got=%0d addrs want=3", addr_log.size()); end
        vectors++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL bp_head got=%b/%h want=1/fffffffc", m_axis_tvalid, m_axis_tdata); end
        for (int k = 0; k < 60 && done_cnt == 0; k++) tick(1'b1);
        vectors++; if (beat_q.size() != 8 || done_cnt != 1) begin miscompares++; $display("FAIL bp_count got=%0d/%0d want=8/1", beat_q.size(), done_cnt); end
        for (int i = 0; i < 8; i++) begin
            exp = 32'(i - 4);
            vectors++;
            if (i >= beat_q.size() || beat_q[i] !== exp || last_q[i] !== (i == 7)) begin
                miscompares++;
                $display("FAIL bp_beat%0d got=%h want=%h", i, (i < beat_q.size()) ? beat_q[i] : 32'hx, exp);
            end
        end
        vectors++; if (stable_err != 0) begin miscompares++; $display("FAIL bp_hold got=%0d want=0", stable_err); end
`ifdef GAT_FEAT_STREAM_STALL_CNT_EN
        vectors++; if (stall_cnt !== 32'(stall_seen)) begin miscompares++; $display("FAIL bp_stall_cnt got=%0d want=%0d", stall_cnt, stall_seen); end
`endif
        tick(1'b1);
    endtask

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        gat_ready     = 1'b0;
        m_axis_tready = 1'b0;
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        clear_logs();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_second_pulse();
        test_reset_mid();
        test_held_high();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
